// File: rtl/rcc_div_sel_ctrl.sv
// rcc_div_sel_ctrl
// Round-robin sequencer for the dynamic clock divider select. One request is
// granted at a time: the downstream clock is gated, the new select is applied,
// the block waits for the divider to report it is running, then ungates and
// acknowledges the requester.
//
// Parameters:
//   N_REQ       - number of requesters (2..8)
//   GATE_CYC    - cycles gated before div_sel changes (>=1)
//   SETTLE_CYC  - minimum cycles after the change before div_en is honoured (>=1)
//   TIMEOUT_CYC - lock-wait limit from WAIT_LOCK entry (> SETTLE_CYC)
//
// Ports:
//   i_clk       - clock
//   rst         - asynchronous active-high reset
//   req         - per-requester request level
//   req_sel     - requested select, slice i is [3i+2:3i]
//   ack         - one-cycle completion pulse per requester
//   err         - one-cycle pulse with ack when the lock wait timed out
//   div_sel     - registered select to the divider
//   div_en      - divider running indication
//   clk_gate_en - 1 = downstream clock enabled
//   busy        - high whenever the sequencer is not idle
//
// Optional feature macro: RCC_DIV_TIMEOUT_EN adds the lock-wait timeout and
// the err pulse; when undefined err is tied low and WAIT_LOCK waits forever.
module rcc_div_sel_ctrl #(
    parameter int N_REQ       = 4,
    parameter int GATE_CYC    = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_sel,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic [2:0]           div_sel,
    input  logic                 div_en,
    output logic                 clk_gate_en,
    output logic                 busy
);

    localparam int IW     = $clog2(N_REQ);
    localparam int MAX_GS = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    // Counter is wide enough for either build so both share one definition.
    localparam int MAX_ALL = (MAX_GS > TIMEOUT_CYC) ? MAX_GS : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
`ifdef RCC_DIV_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(MAX_ALL - 1);
`else
    localparam logic [CW-1:0] CNT_SAT     = CW'(MAX_GS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GATE   = 3'd1,
        S_APPLY  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNGATE = 3'd4,
        S_ACK    = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   gnt_reg;
    logic [2:0]      tgt_reg;
    logic [2:0]      div_sel_reg;
    logic [2:0]      sel_slice [N_REQ];
    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic [IW:0]     arb_sum;
    logic            settled;
    logic            timeout_hit;
    logic            ack_phase;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign sel_slice[gi] = req_sel[3*gi +: 3];
        end
    endgenerate

    // Round-robin search starting just above the last granted index.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (arb_sum >= (IW+1)'(N_REQ))
                arb_sum = arb_sum - (IW+1)'(N_REQ);
            if (!arb_found && req[arb_sum[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[IW-1:0];
            end
        end
    end

    assign settled = (cnt_reg >= SETTLE_LAST) && div_en;
`ifdef RCC_DIV_TIMEOUT_EN
    assign timeout_hit = !settled && (cnt_reg == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (arb_found)
                    state_next = (sel_slice[arb_idx] == div_sel_reg) ? S_ACK : S_GATE;
            end
            S_GATE:   if (cnt_reg == GATE_LAST) state_next = S_APPLY;
            S_APPLY:  state_next = S_WAIT;
            S_WAIT:   if (settled || timeout_hit) state_next = S_UNGATE;
            S_UNGATE: state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic (decoded from registered state only)
    always_comb begin
        clk_gate_en = !((state_reg == S_GATE) || (state_reg == S_APPLY) ||
                        (state_reg == S_WAIT));
        busy        = (state_reg != S_IDLE);
        ack_phase   = (state_reg == S_ACK);
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack[gi] = ack_phase && (gnt_reg == IW'(gi));
        end
    endgenerate

    assign div_sel = div_sel_reg;

    // Datapath: per-state cycle counter, grant latch, select register.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            ptr_reg     <= IW'(N_REQ - 1);
            gnt_reg     <= '0;
            tgt_reg     <= 3'b000;
            div_sel_reg <= 3'b000;
        end else begin
            // Counter restarts on every state change and saturates otherwise.
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_SAT)
                cnt_reg <= cnt_reg + 1'b1;

            if (state_reg == S_IDLE && arb_found) begin
                gnt_reg <= arb_idx;
                ptr_reg <= arb_idx;
                tgt_reg <= sel_slice[arb_idx];
            end

            if (state_reg == S_APPLY)
                div_sel_reg <= tgt_reg;
        end
    end

`ifdef RCC_DIV_TIMEOUT_EN
    logic err_flag_reg;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst)
            err_flag_reg <= 1'b0;
        else if (state_reg == S_IDLE)
            err_flag_reg <= 1'b0;
        else if (state_reg == S_WAIT && timeout_hit)
            err_flag_reg <= 1'b1;
    end

    assign err = ack_phase && err_flag_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rcc_div_sel_ctrl.sv
// Directed testbench for rcc_div_sel_ctrl (default parameters, N_REQ=4).
// Cycle numbering: cycle 1 is the first cycle a request is seen in IDLE.
module tb_rcc_div_sel_ctrl;

    logic        i_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_sel;
    logic [3:0]  ack;
    logic        err;
    logic [2:0]  div_sel;
    logic        div_en;
    logic        clk_gate_en;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Results of the most recent run_seq call
    int         r_ack_cyc;
    logic [3:0] r_ack_val;
    logic       r_err;
    int         r_gate_low;
    logic       r_bad_chg;
    logic [2:0] r_sel_c3;
    logic [2:0] r_sel_c5;
    logic       r_busy_c2;

    rcc_div_sel_ctrl #(
        .N_REQ(4), .GATE_CYC(2), .SETTLE_CYC(16), .TIMEOUT_CYC(64)
    ) dut (
        .i_clk(i_clk), .rst(rst), .req(req), .req_sel(req_sel), .ack(ack),
        .err(err), .div_sel(div_sel), .div_en(div_en),
        .clk_gate_en(clk_gate_en), .busy(busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one request and measures the sequence; no checking here.
    task automatic run_seq(input int idx, input logic [2:0] sel, input int en_at,
                           input int drop_at, input int max_cyc);
        logic [2:0] prev;
        req = 4'b0000;
        req[idx] = 1'b1;
        req_sel[idx*3 +: 3] = sel;
        div_en = (en_at == 0);
        prev = div_sel;
        r_ack_cyc = 0; r_ack_val = '0; r_err = 1'b0; r_gate_low = 0;
        r_bad_chg = 1'b0; r_sel_c3 = 3'bxxx; r_sel_c5 = 3'bxxx; r_busy_c2 = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (en_at != 0 && c == en_at) div_en = 1'b1;
            if (c == drop_at) req[idx] = 1'b0;
            if (div_sel !== prev && clk_gate_en) r_bad_chg = 1'b1;
            prev = div_sel;
            if (!clk_gate_en) r_gate_low++;
            if (c == 2) r_busy_c2 = busy;
            if (c == 3) r_sel_c3 = div_sel;
            if (c == 5) r_sel_c5 = div_sel;
            if (ack != 4'b0000 && r_ack_cyc == 0) begin
                r_ack_cyc = c;
                r_ack_val = ack;
                r_err     = err;
                req       = 4'b0000;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_sel = '0; div_en = 1'b1;
        tick(); tick();
        checks++; if (div_sel !== 3'b000) begin failures++; $display("FAIL reset_div_sel got=%b exp=000", div_sel); end
        checks++; if (clk_gate_en !== 1'b1) begin failures++; $display("FAIL reset_gate got=%b exp=1", clk_gate_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ack !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL reset_ack_err ack=%b err=%b exp=0000/0", ack, err); end
        rst = 1'b0;
        tick();
        $display("reset: div_sel=%b gate=%b busy=%b", div_sel, clk_gate_en, busy);
    endtask

    task automatic test_change();
        run_seq(1, 3'b101, 0, 0, 40);
        $display("change req1 sel=101: ack_cyc=%0d ack=%b gate_low=%0d", r_ack_cyc, r_ack_val, r_gate_low);
        checks++; if (r_ack_cyc != 22) begin failures++; $display("FAIL change_ack_cycle got=%0d exp=22", r_ack_cyc); end
        checks++; if (r_ack_val !== 4'b0010) begin failures++; $display("FAIL change_ack_val got=%b exp=0010", r_ack_val); end
        checks++; if (r_gate_low != 19) begin failures++; $display("FAIL change_gate_low got=%0d exp=19", r_gate_low); end
        checks++; if (r_sel_c3 !== 3'b000) begin failures++; $display("FAIL change_sel_in_gate got=%b exp=000", r_sel_c3); end
        checks++; if (r_sel_c5 !== 3'b101) begin failures++; $display("FAIL change_sel_in_wait got=%b exp=101", r_sel_c5); end
        checks++; if (r_bad_chg !== 1'b0) begin failures++; $display("FAIL change_sel_ungated got=%b exp=0", r_bad_chg); end
        checks++; if (r_busy_c2 !== 1'b1) begin failures++; $display("FAIL change_busy got=%b exp=1", r_busy_c2); end
        checks++; if (div_sel !== 3'b101 || busy !== 1'b0) begin failures++; $display("FAIL change_final sel=%b busy=%b exp=101/0", div_sel, busy); end
        checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL change_err got=%b exp=0", r_err); end
    endtask

    task automatic test_equal();
        run_seq(2, 3'b101, 0, 0, 10);
        $display("equal req2 sel=101: ack_cyc=%0d ack=%b gate_low=%0d", r_ack_cyc, r_ack_val, r_gate_low);
        checks++; if (r_ack_cyc != 2) begin failures++; $display("FAIL equal_ack_cycle got=%0d exp=2", r_ack_cyc); end
        checks++; if (r_ack_val !== 4'b0100) begin failures++; $display("FAIL equal_ack_val got=%b exp=0100", r_ack_val); end
        checks++; if (r_gate_low != 0) begin failures++; $display("FAIL equal_gate_low got=%0d exp=0", r_gate_low); end
        checks++; if (div_sel !== 3'b101) begin failures++; $display("FAIL equal_div_sel got=%b exp=101", div_sel); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack [4];
        int         exp_cyc [4];
        logic [3:0] got_ack [4];
        int         got_cyc [4];
        int         n;
        exp_ack = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        exp_cyc = '{2, 4, 6, 8};
        // Fresh reset puts the pointer at N_REQ-1 so index 0 is first.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_sel = 12'h000; div_en = 1'b1;
        req = 4'b1101;
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            if (ack != 4'b0000) begin
                got_ack[n] = ack; got_cyc[n] = c; n++;
                if (n == 4) req = 4'b0000;
            end
            tick();
        end
        tick();
        checks++; if (n != 4) begin failures++; $display("FAIL rr_ack_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
            $display("rr grant %0d: ack=%b cycle=%0d", i, got_ack[i], got_cyc[i]);
            checks++; if (got_ack[i] !== exp_ack[i]) begin failures++; $display("FAIL rr_order_%0d got=%b exp=%b", i, got_ack[i], exp_ack[i]); end
            checks++; if (got_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL rr_cycle_%0d got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]); end
        end
    endtask

    task automatic test_lock_wait();
        // div_en low through cycle 43, rises in cycle 44 -> UNGATE 45, ACK 46.
        run_seq(3, 3'b010, 44, 0, 80);
        $display("lock_wait req3 sel=010: ack_cyc=%0d ack=%b gate_low=%0d err=%b", r_ack_cyc, r_ack_val, r_gate_low, r_err);
        checks++; if (r_ack_cyc != 46) begin failures++; $display("FAIL lock_ack_cycle got=%0d exp=46", r_ack_cyc); end
        checks++; if (r_ack_val !== 4'b1000) begin failures++; $display("FAIL lock_ack_val got=%b exp=1000", r_ack_val); end
        checks++; if (r_gate_low != 43) begin failures++; $display("FAIL lock_gate_low got=%0d exp=43", r_gate_low); end
        checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL lock_err got=%b exp=0", r_err); end
        checks++; if (div_sel !== 3'b010) begin failures++; $display("FAIL lock_div_sel got=%b exp=010", div_sel); end
    endtask

`ifdef RCC_DIV_TIMEOUT_EN
    task automatic test_timeout();
        // WAIT_LOCK entered in cycle 5, expires after 64 cycles (cycle 68).
        run_seq(0, 3'b111, 999, 0, 100);
        $display("timeout req0 sel=111: ack_cyc=%0d ack=%b err=%b gate_low=%0d", r_ack_cyc, r_ack_val, r_err, r_gate_low);
        checks++; if (r_ack_cyc != 70) begin failures++; $display("FAIL timeout_ack_cycle got=%0d exp=70", r_ack_cyc); end
        checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", r_err); end
        checks++; if (r_ack_val !== 4'b0001) begin failures++; $display("FAIL timeout_ack_val got=%b exp=0001", r_ack_val); end
        checks++; if (r_gate_low != 67) begin failures++; $display("FAIL timeout_gate_low got=%0d exp=67", r_gate_low); end
        checks++; if (div_sel !== 3'b111) begin failures++; $display("FAIL timeout_div_sel got=%b exp=111", div_sel); end
        div_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid();
        logic [3:0] ack_seen;
        req = 4'b0010; req_sel[5:3] = 3'b110; div_en = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        checks++; if (div_sel !== 3'b110 || clk_gate_en !== 1'b0) begin failures++; $display("FAIL midrst_pre sel=%b gate=%b exp=110/0", div_sel, clk_gate_en); end
        rst = 1'b1;
        #1;
        checks++; if (div_sel !== 3'b000) begin failures++; $display("FAIL midrst_div_sel got=%b exp=000", div_sel); end
        checks++; if (clk_gate_en !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_gate_busy gate=%b busy=%b exp=1/0", clk_gate_en, busy); end
        ack_seen = ack;
        tick();
        ack_seen = ack_seen | ack;
        req = 4'b0000; rst = 1'b0; div_en = 1'b1;
        tick();
        ack_seen = ack_seen | ack;
        checks++; if (ack_seen !== 4'b0000) begin failures++; $display("FAIL midrst_no_ack got=%b exp=0000", ack_seen); end
        run_seq(0, 3'b100, 0, 0, 40);
        $display("after reset req0 sel=100: ack_cyc=%0d ack=%b gate_low=%0d", r_ack_cyc, r_ack_val, r_gate_low);
        checks++; if (r_ack_cyc != 22) begin failures++; $display("FAIL postrst_ack_cycle got=%0d exp=22", r_ack_cyc); end
        checks++; if (r_ack_val !== 4'b0001) begin failures++; $display("FAIL postrst_ack_val got=%b exp=0001", r_ack_val); end
        checks++; if (div_sel !== 3'b100) begin failures++; $display("FAIL postrst_div_sel got=%b exp=100", div_sel); end
    endtask

    task automatic test_drop_req();
        run_seq(1, 3'b011, 0, 2, 40);
        $display("drop req1 sel=011: ack_cyc=%0d ack=%b gate_low=%0d", r_ack_cyc, r_ack_val, r_gate_low);
        checks++; if (r_ack_cyc != 22) begin failures++; $display("FAIL drop_ack_cycle got=%0d exp=22", r_ack_cyc); end
        checks++; if (r_ack_val !== 4'b0010) begin failures++; $display("FAIL drop_ack_val got=%b exp=0010", r_ack_val); end
        checks++; if (div_sel !== 3'b011) begin failures++; $display("FAIL drop_div_sel got=%b exp=011", div_sel); end
        checks++; if (r_gate_low != 19) begin failures++; $display("FAIL drop_gate_low got=%0d exp=19", r_gate_low); end
    endtask

    initial begin
        rst = 1'b1; req = '0; req_sel = '0; div_en = 1'b1;
        test_reset();
        test_change();
        test_equal();
        test_round_robin();
        test_lock_wait();
`ifdef RCC_DIV_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_drop_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rcc_div_sel_ctrl.md
# rcc_div_sel_ctrl

Sequencer and arbiter for the 1/2/4/8/16 dynamic clock divider select. Up to N requesters ask for a new divider select. The block grants one request at a time in round-robin order, gates the downstream clock, applies the new `div_sel`, waits for the divider to report `div_en`, and then ungates and acknowledges. It sits between software- or PMU-facing requesters and the divider's `div_sel`/`div_en` pins, with `clk_gate_en` driving the downstream clock gate.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `GATE_CYC`, 2: cycles the clock stays gated before `div_sel` changes (≥1).
- `SETTLE_CYC`, 16: minimum cycles after the change before `div_en` is checked (≥1).
- `TIMEOUT_CYC`, 64: lock-wait limit, counted from WAIT_LOCK entry (only with the macro; must exceed `SETTLE_CYC`).

- `i_clk`, input, 1: single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, N_REQ: per-requester request level.
- `req_sel`, input, 3*N_REQ: requested select; slice i is `[3i+2:3i]`.
- `ack`, output, N_REQ: one-cycle completion pulse per requester.
- `err`, output, 1: one-cycle pulse with `ack` when the lock wait timed out.
- `div_sel`, output, 3: registered select to the divider.
- `div_en`, input, 1: divider running indication.
- `clk_gate_en`, output, 1: 1 = downstream clock enabled.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- Reset values:
  - `div_sel` = 3'b000 (ratio 1), `clk_gate_en` = 1.
  - `ack` = 0, `err` = 0, `busy` = 0.
  - State = IDLE, round-robin pointer = N_REQ-1 (index 0 has first priority).
- IDLE, when any `req` bit is high:
  - Grant the first set index searching upward from pointer+1, with wrap-around.
  - Latch the granted index and its `req_sel` slice into `tgt`.
  - Update the pointer to the granted index.
  - If `tgt` == `div_sel`, go to ACK. Otherwise go to GATE.
- GATE: `clk_gate_en` = 0. Hold for `GATE_CYC` cycles, then go to APPLY.
- APPLY: `div_sel` <= `tgt` (one cycle). Go to WAIT_LOCK.
- WAIT_LOCK: `clk_gate_en` stays 0.
  - Count `SETTLE_CYC` cycles.
  - After that, leave on the first cycle `div_en` is sampled 1 and go to UNGATE.
- UNGATE: `clk_gate_en` = 1. Go to ACK.
- ACK: pulse `ack[granted]` for one cycle, then return to IDLE.
- Selects 000..011 all mean ratio 1 but are treated as distinct values. The equality skip compares all 3 bits.
- `req` must stay high until `ack`. The latched `tgt` is used even if `req` or `req_sel` changes after the grant.
- If `req` drops mid-sequence, the sequence still completes and `ack` still pulses.
- If a requester keeps `req` high after `ack`, that is a new request. It is granted only after the other pending requesters have had a turn.
- Asynchronous `rst` mid-sequence returns every output to its reset value immediately, including `div_sel` = 000 and `clk_gate_en` = 1. No `ack` is issued for the aborted request.

## Timing
- Arbitration uses registered state only. There is no combinational path from `req` to `ack`.
- Changing request, cycles counted from the first cycle `req` is seen high in IDLE:
  - Minimum latency to `ack` = 1 (grant) + GATE_CYC + 1 (APPLY) + SETTLE_CYC + 1 (UNGATE) + 1 (ACK).
  - With defaults and `div_en` already high, `ack` is asserted in cycle 22.
- Equal-select request: `ack` in cycle 2. `clk_gate_en` never drops.
- `clk_gate_en` is low for exactly GATE_CYC + 1 + SETTLE_CYC + (`div_en` wait) cycles.
- `div_sel` changes only while `clk_gate_en` = 0.
- Back-to-back requests: after ACK, IDLE lasts at least one cycle before the next grant.

## Configuration
- `RCC_DIV_TIMEOUT_EN` defined:
  - WAIT_LOCK also counts up to `TIMEOUT_CYC` cycles from entry.
  - On expiry without `div_en`, the block goes to UNGATE. The `ack` cycle also pulses `err`. `div_sel` keeps the new value.
- Not defined:
  - WAIT_LOCK waits for `div_en` indefinitely.
  - `err` is tied to 0, and no timeout counter is built.

## Test plan
- After reset, check `div_sel`=000, `clk_gate_en`=1, `busy`=0. Then `req[1]` with sel 3'b101 and `div_en`=1 → `clk_gate_en` low for 19 cycles, `div_sel`=101 set in APPLY, `ack[1]` pulse in cycle 22.
- `req[2]` with sel equal to the current `div_sel` → `ack[2]` in cycle 2, `clk_gate_en` stays 1.
- `req[0]`, `req[2]` and `req[3]` all held high → `ack` order 0, 2, 3, then 0 again on repeat. No requester is starved.
- Hold `div_en`=0 for 40 cycles after APPLY → UNGATE happens only after `div_en` rises. With the macro and `TIMEOUT_CYC`=64, holding `div_en`=0 forever → `ack` and `err` pulse together.
- Assert `rst` during WAIT_LOCK → immediate `div_sel`=000, `clk_gate_en`=1, no `ack`. A new request after reset completes normally.
- Drop `req[1]` during GATE → the sequence completes and `ack[1]` still pulses.
